// File: rtl/arb_mux_rr.sv
// N-input valid/ready arbitrating multiplexer with a registered output stage.
// Grants by round-robin or fixed priority and holds the grant for the whole of a multi-beat packet.
module arb_mux_rr #(
   parameter  int data_width = 32,
   parameter  int num_in     = 4,
   parameter  int prio_mode  = 0,
   localparam int sel_width  = $clog2(num_in)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [num_in*data_width-1:0] in_data,
   input  logic [num_in-1:0]            in_valid,
   input  logic [num_in-1:0]            in_last,
   output logic [num_in-1:0]            in_ready,
   output logic [data_width-1:0]        out_data,
   output logic                         out_valid,
   output logic                         out_last,
   output logic [sel_width-1:0]         out_sel,
   input  logic                         out_ready
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t                state_r;
   logic [sel_width-1:0]  rr_ptr_r;
   logic [sel_width-1:0]  lock_idx_r;

   logic                  space_s;
   logic                  grant_ok_s;
   logic [sel_width-1:0]  grant_idx_s;
   logic                  take_s;
   logic                  xfer_s;
   logic [data_width-1:0] sel_data_s;
   logic                  sel_last_s;
   logic [sel_width-1:0]  next_ptr_s;
   int                    dist_s;
   int                    best_s;

   // Arbitration: locked owner, else the valid requester nearest the priority origin
   always_comb begin
      grant_ok_s  = 1'b0;
      grant_idx_s = {sel_width{1'b0}};
      take_s      = 1'b0;
      dist_s      = 0;
      best_s      = num_in;
      if (state_r == ST_LOCKED) begin
         grant_ok_s  = 1'b1;
         grant_idx_s = lock_idx_r;
      end else begin
         for (int i = 0; i < num_in; i++) begin
            // Distance from the origin: index itself, or upward distance from rr_ptr modulo num_in
            dist_s = (prio_mode == 1) ? i :
                     ((i >= int'(rr_ptr_r)) ? i - int'(rr_ptr_r) : i + num_in - int'(rr_ptr_r));
            take_s      = in_valid[i] && (dist_s < best_s);
            best_s      = take_s ? dist_s : best_s;
            grant_ok_s  = take_s ? 1'b1 : grant_ok_s;
            grant_idx_s = take_s ? sel_width'(i) : grant_idx_s;
         end
      end
   end

   // Per-input ready, selected beat and the pointer value that follows this grant
   always_comb begin
      space_s    = !out_valid || out_ready;
      in_ready   = {num_in{1'b0}};
      sel_data_s = {data_width{1'b0}};
      sel_last_s = 1'b0;
      for (int i = 0; i < num_in; i++) begin
         if (sel_width'(i) == grant_idx_s) begin
            in_ready[i] = reset && space_s && grant_ok_s;
            sel_data_s  = in_data[i*data_width +: data_width];
            sel_last_s  = in_last[i];
         end else begin
            in_ready[i] = 1'b0;
         end
      end
      xfer_s     = |(in_valid & in_ready);
      next_ptr_s = (grant_idx_s == sel_width'(num_in - 1)) ? {sel_width{1'b0}}
                                                           : grant_idx_s + sel_width'(1);
   end

   // Output register, packet-lock state machine and round-robin pointer
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         rr_ptr_r   <= {sel_width{1'b0}};
         lock_idx_r <= {sel_width{1'b0}};
         out_valid  <= 1'b0;
         out_data   <= {data_width{1'b0}};
         out_last   <= 1'b0;
         out_sel    <= {sel_width{1'b0}};
      end else begin
         if (xfer_s) begin
            out_valid <= 1'b1;
            out_data  <= sel_data_s;
            out_last  <= sel_last_s;
            out_sel   <= grant_idx_s;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end else begin
            out_valid <= out_valid;
         end
         case (state_r)
            ST_IDLE: begin
               if (xfer_s && !sel_last_s) begin
                  state_r    <= ST_LOCKED;
                  lock_idx_r <= grant_idx_s;
               end else begin
                  state_r    <= ST_IDLE;
               end
            end
            ST_LOCKED: begin
               if (xfer_s && sel_last_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_LOCKED;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
         // Pointer advances on every packet-completing beat, whatever the mode
         if (xfer_s && sel_last_s) begin
            rr_ptr_r <= next_ptr_s;
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_rr.sv
// Bench for arb_mux_rr: three instances (4-input round-robin, 3-input round-robin,
// 4-input fixed priority) share one stimulus; a queue-free reference model checks all of them each cycle.
module tb_arb_mux_rr;

   logic          clk = 1'b0;
   logic          reset;
   logic [127:0]  data;
   logic [3:0]    valid;
   logic [3:0]    last;
   logic          out_ready;

   logic [3:0]    rdy0;
   logic [2:0]    rdy3;
   logic [3:0]    rdyp;
   logic [31:0]   od [3];
   logic          ov [3];
   logic          ol [3];
   logic [1:0]    os [3];

   // reference model state, one slot per instance
   int            nn [3] = '{4, 3, 4};
   int            md [3] = '{0, 0, 1};
   bit            m_lock [3];
   int            m_own [3];
   int            m_ptr [3];
   bit            m_ov [3];
   logic [31:0]   m_od [3];
   bit            m_ol [3];
   int            m_os [3];

   int            n_chk = 0;
   int            n_fail = 0;
   bit            chk_en = 1'b0;

   always #5 clk = ~clk;

   arb_mux_rr #(.data_width(32), .num_in(4), .prio_mode(0)) dut (
      .clk(clk), .reset(reset), .in_data(data), .in_valid(valid), .in_last(last),
      .in_ready(rdy0), .out_data(od[0]), .out_valid(ov[0]), .out_last(ol[0]),
      .out_sel(os[0]), .out_ready(out_ready));

   arb_mux_rr #(.data_width(32), .num_in(3), .prio_mode(0)) dut3 (
      .clk(clk), .reset(reset), .in_data(data[95:0]), .in_valid(valid[2:0]), .in_last(last[2:0]),
      .in_ready(rdy3), .out_data(od[1]), .out_valid(ov[1]), .out_last(ol[1]),
      .out_sel(os[1]), .out_ready(out_ready));

   arb_mux_rr #(.data_width(32), .num_in(4), .prio_mode(1)) dutp (
      .clk(clk), .reset(reset), .in_data(data), .in_valid(valid), .in_last(last),
      .in_ready(rdyp), .out_data(od[2]), .out_valid(ov[2]), .out_last(ol[2]),
      .out_sel(os[2]), .out_ready(out_ready));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // who the model grants: lock owner, else first valid in search order
   function automatic int pick(input int m);
      int idx;
      if (m_lock[m]) return m_own[m];
      for (int k = 0; k < nn[m]; k++) begin
         idx = (md[m] == 1) ? k : (m_ptr[m] + k) % nn[m];
         if (valid[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready(input int m);
      int g;
      g = pick(m);
      if (!reset || (m_ov[m] && !out_ready) || g < 0) return 4'b0000;
      return 4'b0001 << g;
   endfunction

   // compare all instances, then advance the model to the state after the next rising edge
   always @(negedge clk) begin
      int g;
      logic [3:0] r;
      if (chk_en) begin
         chk("m0 in_ready", 32'(rdy0), 32'(exp_ready(0)));
         chk("m1 in_ready", 32'(rdy3), 32'(exp_ready(1)));
         chk("m2 in_ready", 32'(rdyp), 32'(exp_ready(2)));
         for (int m = 0; m < 3; m++) begin
            chk($sformatf("m%0d out_valid", m), 32'(ov[m]), 32'(m_ov[m]));
            chk($sformatf("m%0d out_last", m), 32'(ol[m]), 32'(m_ol[m]));
            chk($sformatf("m%0d out_sel", m), 32'(os[m]), 32'(m_os[m]));
            chk($sformatf("m%0d out_data", m), od[m], m_od[m]);
         end
      end
      for (int m = 0; m < 3; m++) begin
         g = pick(m);
         r = exp_ready(m);
         if (!reset) begin
            m_lock[m] = 1'b0; m_own[m] = 0; m_ptr[m] = 0;
            m_ov[m] = 1'b0; m_od[m] = 32'h0; m_ol[m] = 1'b0; m_os[m] = 0;
         end else if ((r & valid) != 4'b0000) begin
            m_ov[m] = 1'b1;
            m_os[m] = g;
            m_od[m] = data[32*g +: 32];
            m_ol[m] = last[g];
            if (last[g]) begin
               m_lock[m] = 1'b0;
               m_ptr[m]  = (g + 1) % nn[m];
            end else begin
               m_lock[m] = 1'b1;
               m_own[m]  = g;
            end
         end else if (out_ready) begin
            m_ov[m] = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_data(input int i, input logic [31:0] v);
      data[32*i +: 32] = v;
   endtask

   initial begin
      reset = 1'b0; valid = 4'hF; last = 4'hF; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_data(i, 32'hA0 + 32'(i));

      // reset held for two edges with every input requesting
      tick(); tick();
      chk_en = 1'b1;
      chk("rst in_ready", 32'(rdy0), 32'h0);
      chk("rst out_valid", 32'(ov[0]), 32'h0);
      chk("rst out_data", od[0], 32'h0);
      chk("rst out_sel", 32'(os[0]), 32'h0);
      reset = 1'b1;
      settle();
      chk("first grant", 32'(rdy0), 32'h1);

      // round-robin rotation
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rr sel", 32'(os[0]), 32'(k % 4));
         chk("rr data", od[0], 32'hA0 + 32'(k % 4));
      end

      // three-beat packet on input 2 while input 0 waits
      valid = 4'b0101; last = 4'b0000; set_data(2, 32'hB0);
      settle(); chk("lock first ready", 32'(rdy0), 32'h4);
      tick(); chk("lock sel b0", 32'(os[0]), 32'h2); chk("lock data b0", od[0], 32'hB0);
      set_data(2, 32'hB1);
      settle(); chk("lock ready b1", 32'(rdy0), 32'h4);
      tick(); chk("lock sel b1", 32'(os[0]), 32'h2); chk("lock data b1", od[0], 32'hB1);
      valid = 4'b0001;
      settle(); chk("lock gap ready", 32'(rdy0), 32'h4);
      tick(); chk("lock gap valid", 32'(ov[0]), 32'h0);
      settle(); chk("lock gap ready2", 32'(rdy0), 32'h4);
      tick(); chk("lock gap valid2", 32'(ov[0]), 32'h0);
      valid = 4'b0101; last = 4'b0100; set_data(2, 32'hB2);
      tick(); chk("lock sel b2", 32'(os[0]), 32'h2); chk("lock data b2", od[0], 32'hB2);
      chk("lock last b2", 32'(ol[0]), 32'h1);
      last = 4'b0101;
      settle(); chk("after lock ready", 32'(rdy0), 32'h1);
      tick(); chk("after lock sel", 32'(os[0]), 32'h0); chk("after lock data", od[0], 32'hA0);

      // backpressure holds the beat, then pop and push in one cycle
      valid = 4'hF; last = 4'hF; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle(); chk("bp ready", 32'(rdy0), 32'h0);
         tick();
         chk("bp valid", 32'(ov[0]), 32'h1);
         chk("bp sel", 32'(os[0]), 32'h0);
         chk("bp data", od[0], 32'hA0);
      end
      out_ready = 1'b1;
      settle(); chk("bp release ready", 32'(rdy0), 32'h2);
      tick(); chk("bp reload valid", 32'(ov[0]), 32'h1);
      chk("bp reload sel", 32'(os[0]), 32'h1); chk("bp reload data", od[0], 32'hA1);

      // fixed priority, then reset in the middle of a locked packet
      valid = 4'b1010; last = 4'hF;
      for (int k = 0; k < 3; k++) begin
         tick(); chk("prio sel", 32'(os[2]), 32'h1);
      end
      last = 4'h0;
      tick(); chk("prio lock sel", 32'(os[2]), 32'h1);
      valid = 4'b1000;
      settle(); chk("prio locked ready", 32'(rdyp), 32'h2); chk("rr locked ready", 32'(rdy0), 32'h2);
      tick();
      reset = 1'b0;
      settle(); chk("in reset ready", 32'(rdyp), 32'h0);
      tick(); tick();
      chk("post rst valid p", 32'(ov[2]), 32'h0); chk("post rst valid rr", 32'(ov[0]), 32'h0);
      reset = 1'b1; last = 4'hF;
      settle();
      chk("post rst idle p", 32'(rdyp), 32'h8); chk("post rst idle rr", 32'(rdy0), 32'h8);
      chk("post rst dut3 ready", 32'(rdy3), 32'h0);
      tick();

      // three-input wrap: pointer 0 -> 2 -> 0 -> 1
      valid = 4'b0010;
      tick(); chk("wrap sel 1", 32'(os[1]), 32'h1);
      valid = 4'b0101;
      settle(); chk("wrap ready 2", 32'(rdy3), 32'h4);
      tick(); chk("wrap sel 2", 32'(os[1]), 32'h2);
      settle(); chk("wrap ready 0", 32'(rdy3), 32'h1);
      tick(); chk("wrap sel 0", 32'(os[1]), 32'h0);
      valid = 4'b0111;
      settle(); chk("wrap ready ptr1", 32'(rdy3), 32'h2);
      tick(); chk("wrap sel ptr1", 32'(os[1]), 32'h1);
      valid = 4'b0000;
      tick(); tick();
      chk("drain valid", 32'(ov[1]), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/arb_mux_rr.md
# arb_mux_rr

Parametrised N-input, valid/ready arbitrating multiplexer with a registered output stage. It generalises the fixed 4-to-1 combinational select to `num_in` requesters of `data_width` bits. Instead of an external control input, it generates its own grant by round-robin or fixed priority, and it locks the grant across multi-beat packets. It sits where several producers share one consumer port, such as I-fetch and D-access sharing the memory port, or multiple writeback sources sharing one bus.

## Interface
- `data_width`, default 32: payload width per input.
- `num_in`, default 4: number of requesters; must be at least 2; need not be a power of two.
- `prio_mode`, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `sel_width`, a localparam equal to `$clog2(num_in)`.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low; state resets at a rising edge with `reset`==0.
- `in_data`, input, `num_in*data_width`: packed payloads; input i occupies bits [i*data_width +: data_width].
- `in_valid`, input, `num_in`: per-input request and beat valid.
- `in_last`, input, `num_in`: marks the final beat of a packet; 1 for single-beat transfers.
- `in_ready`, output, `num_in`: per-input accept; one-hot or zero.
- `out_data`, output, `data_width`: registered payload.
- `out_valid`, output, 1: the output register holds a beat.
- `out_last`, output, 1: registered copy of `in_last` for that beat.
- `out_sel`, output, `sel_width`: index of the input that supplied `out_data`.
- `out_ready`, input, 1: the consumer accepts the beat.

## Operation
- `space = !out_valid || out_ready`. A transfer on input g happens when `in_valid[g] && in_ready[g]`.
- `in_ready[g] = space && (g == grant) && state permits`. `in_ready` is all zero while `reset`==0.
- State machine:
  - **IDLE**: when `space` is high and any `in_valid` is set, grant one input.
    - prio_mode 0: grant the first requester at or after `rr_ptr`, searching upward modulo `num_in`.
    - prio_mode 1: grant the lowest-index requester.
    - If the transfer has `in_last`=0, go to LOCKED with `lock_idx`=g.
    - If the transfer has `in_last`=1, stay in IDLE.
  - **LOCKED**: grant only `lock_idx`, even when `in_valid[lock_idx]`=0; all other `in_ready` stay 0.
    - A transfer with `in_last`=1 returns to IDLE.
- `rr_ptr` updates to (g+1) mod `num_in` on the packet-completing transfer, meaning the beat with `in_last`=1, in both IDLE and LOCKED.
  - The pointer wraps from `num_in`-1 to 0, including for non-power-of-two `num_in`.
  - Under prio_mode 1, `rr_ptr` is ignored but still updated.
- Output register:
  - On a transfer, load `out_data`=`in_data`[g], `out_last`=`in_last`[g], `out_sel`=g, and set `out_valid`=1.
  - If `out_ready` is high and there is no transfer, clear `out_valid`; data fields hold their value.
- Simultaneous pop and push in the same cycle: the register reloads and `out_valid` stays 1.
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `out_sel`=0, state=IDLE, `rr_ptr`=0, `lock_idx`=0.
- Reset mid-packet: the lock is abandoned and any beat in the output register is discarded. Arbitration resumes from `rr_ptr`=0.

## Timing
- Grant is combinational within the cycle of the request. There is no arbitration bubble.
- Latency from a transfer at edge k to `out_valid`=1 is 1 cycle, visible after edge k.
- Throughput is 1 beat per cycle while `out_ready`=1, including back-to-back packets from different inputs.
- Backpressure: with `out_valid`=1 and `out_ready`=0, every `in_ready` is 0 and all output fields hold.
- Once a packet's first beat is accepted, no beat from another input is accepted until that packet's last beat is accepted.

## Test plan
- **Reset.** Hold `reset`=0 for 2 edges with all `in_valid`=1111. Required: `in_ready`=0000, `out_valid`=0, `out_data`=0, `out_sel`=0. After release, the first grant goes to input 0.
- **Round-robin fairness.** Defaults, all inputs valid and last=1, `out_ready`=1. Required: `out_sel` sequence 0,1,2,3,0,1 on consecutive cycles. Each `out_data` matches `in_data` of the selected input, e.g. 32'hA0+i.
- **Packet lock.** Input 2 sends 3 beats (last on the 3rd) while input 0 stays valid. Required: `out_sel`=2,2,2 then 0; `in_ready[0]`=0 during the lock. Also drop `in_valid[2]` mid-packet and require that no other input is granted.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles with a beat held. Required: `out_data`, `out_sel`, and `out_valid`=1 stable; `in_ready`=0. When `out_ready` rises, a pop and a new load occur in the same cycle.
- **Non-power-of-two wrap.** With `num_in`=3, inputs 2 and 0 valid, `rr_ptr`=2. Required: grant 2, then 0, and `rr_ptr` wraps 2 to 0 to 1.
- **Fixed priority and reset mid-packet.** With prio_mode=1, inputs 1 and 3 valid: grant is always 1. Assert `reset`=0 during a locked packet; after release, state is IDLE and `out_valid`=0.
